ball_bouncer: RTL

BALL_BOUNCER -- requirements
Module: ball_bouncer

---
 rtl/ball_bouncer_pkg.sv | 34 +++
 rtl/bouncer_axis.sv | 61 ++++++
 rtl/ball_bouncer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ball_bouncer_pkg.sv
// Shared types and constants for the ball bouncer: FSM states, display register offsets,
// and the optional colour palette (present only when COLOR_CYCLE_EN is defined).
package ball_bouncer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    UPDATE,
    WR_XL,
    WR_XH,
    WR_YL,
    WR_YH
`ifdef COLOR_CYCLE_EN
    ,
    WR_R,
    WR_G,
    WR_B
`endif
  } state_t;

  localparam logic [2:0] ADDR_XL = 3'd3;
  localparam logic [2:0] ADDR_XH = 3'd4;
  localparam logic [2:0] ADDR_YL = 3'd5;
  localparam logic [2:0] ADDR_YH = 3'd6;

`ifdef COLOR_CYCLE_EN
  localparam logic [2:0] ADDR_R = 3'd0;
  localparam logic [2:0] ADDR_G = 3'd1;
  localparam logic [2:0] ADDR_B = 3'd2;

  // Background colours as {R,G,B}, selected by the low bits of the bounce count.
  localparam logic [23:0] PALETTE [4] = '{24'h000080, 24'h800000, 24'h008000, 24'h808000};
`endif

endpackage

// File: rtl/bouncer_axis.sv
// One axis of ball motion: position/direction registers and the wall-clamp rule.
// pos_o is the position as it will be after this cycle (equals the register when not stepping).
module bouncer_axis #(
  parameter int W    = 11,
  parameter int MAX  = 639,
  parameter int SIZE = 30,
  parameter int V    = 2,
  parameter int P0   = 400
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step_i,
  output logic [W-1:0] pos_o,
  output logic         bounce_o
);

  localparam logic [W:0] HI = (W+1)'(MAX - SIZE);
  localparam logic [W:0] LO = (W+1)'(SIZE + V);

  logic [W-1:0] pos_q, pos_d;
  logic         dir_q, dir_d;

  // Compare one bit wider so pos+V cannot wrap before the limit test.
  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    bounce_o = 1'b0;
    if (step_i) begin
      if (dir_q) begin
        if (({1'b0, pos_q} + (W+1)'(V)) > HI) begin
          pos_d    = W'(MAX - SIZE);
          dir_d    = 1'b0;
          bounce_o = 1'b1;
        end else begin
          pos_d = pos_q + W'(V);
        end
      end else begin
        if ({1'b0, pos_q} < LO) begin
          pos_d    = W'(SIZE);
          dir_d    = 1'b1;
          bounce_o = 1'b1;
        end else begin
          pos_d = pos_q - W'(V);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_q <= W'(P0);
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos_o = pos_d;

endmodule

// File: rtl/ball_bouncer.sv
// Per-frame ball update and Avalon-MM write sequencer for the display peripheral.
// Optional macro COLOR_CYCLE_EN adds background-colour writes on frames with a bounce.
module ball_bouncer
  import ball_bouncer_pkg::*;
#(
  parameter int XMAX      = 639,
  parameter int YMAX      = 479,
  parameter int BALL_SIZE = 30,
  parameter int VX        = 2,
  parameter int VY        = 1,
  parameter int X0        = 400,
  parameter int Y0        = 300
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync_n,
  input  logic       enable,
  input  logic       waitrequest,
  output logic       chipselect,
  output logic       write,
  output logic [2:0] address,
  output logic [7:0] writedata,
  output logic       busy,
  output logic [7:0] bounce_count
);

  state_t      state_q, state_d;
  logic        vs_q, vs_prev_q;
  logic        trigger, step, bx, by;
  logic [10:0] x_d;
  logic [9:0]  y_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
`ifdef COLOR_CYCLE_EN
  logic        fb_q, fb_d;
`endif

  assign trigger = vs_prev_q & ~vs_q;
  assign step    = (state_q == UPDATE);

  bouncer_axis #(.W(11), .MAX(XMAX), .SIZE(BALL_SIZE), .V(VX), .P0(X0)) u_axis_x (
    .clk(clk), .reset_n(reset_n), .step_i(step), .pos_o(x_d), .bounce_o(bx)
  );

  bouncer_axis #(.W(10), .MAX(YMAX), .SIZE(BALL_SIZE), .V(VY), .P0(Y0)) u_axis_y (
    .clk(clk), .reset_n(reset_n), .step_i(step), .pos_o(y_d), .bounce_o(by)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef COLOR_CYCLE_EN
    fb_d    = fb_q;
`endif
    case (state_q)
      IDLE:   if (trigger && enable) state_d = UPDATE;
      UPDATE: begin
        state_d = WR_XL;
        if (bx || by) cnt_d = cnt_q + 8'd1;
`ifdef COLOR_CYCLE_EN
        fb_d = bx | by;
`endif
      end
      WR_XL:  if (!waitrequest) state_d = WR_XH;
      WR_XH:  if (!waitrequest) state_d = WR_YL;
      WR_YL:  if (!waitrequest) state_d = WR_YH;
`ifdef COLOR_CYCLE_EN
      WR_YH:  if (!waitrequest) state_d = fb_q ? WR_R : IDLE;
      WR_R:   if (!waitrequest) state_d = WR_G;
      WR_G:   if (!waitrequest) state_d = WR_B;
      WR_B:   if (!waitrequest) state_d = IDLE;
`else
      WR_YH:  if (!waitrequest) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they are registered; while stalled the
  // state and positions hold, which keeps address/data stable.
  always_comb begin
    wr_d   = 1'b1;
    addr_d = 3'd0;
    data_d = 8'd0;
    case (state_d)
      WR_XL: begin addr_d = ADDR_XL; data_d = x_d[7:0];            end
      WR_XH: begin addr_d = ADDR_XH; data_d = {5'd0, x_d[10:8]};   end
      WR_YL: begin addr_d = ADDR_YL; data_d = y_d[7:0];            end
      WR_YH: begin addr_d = ADDR_YH; data_d = {6'd0, y_d[9:8]};    end
`ifdef COLOR_CYCLE_EN
      WR_R:  begin addr_d = ADDR_R;  data_d = PALETTE[cnt_d[1:0]][23:16]; end
      WR_G:  begin addr_d = ADDR_G;  data_d = PALETTE[cnt_d[1:0]][15:8];  end
      WR_B:  begin addr_d = ADDR_B;  data_d = PALETTE[cnt_d[1:0]][7:0];   end
`endif
      default: wr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      vs_q      <= 1'b1;
      vs_prev_q <= 1'b1;
      cnt_q     <= 8'd0;
      wr_q      <= 1'b0;
      addr_q    <= 3'd0;
      data_q    <= 8'd0;
`ifdef COLOR_CYCLE_EN
      fb_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      vs_q      <= vsync_n;
      vs_prev_q <= vs_q;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
`ifdef COLOR_CYCLE_EN
      fb_q      <= fb_d;
`endif
    end
  end

  assign write        = wr_q;
  assign chipselect   = wr_q;
  assign address      = addr_q;
  assign writedata    = data_q;
  assign busy         = (state_q != IDLE);
  assign bounce_count = cnt_q;

endmodule
